// File: rtl/aes_key_sched_pkg.sv
// Shared types, round-constant table and byte-level helpers for the AES-128 key schedule.
package aes_key_sched_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] word_t;
  typedef word_t [3:0] block_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

  localparam byte_t RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic word_t rot_word(input word_t w);
    return {w[0], w[3], w[2], w[1]};
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    byte_t y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic byte_t sbox_byte(input byte_t a);
    byte_t s;
    byte_t p;
    p = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      p = gf_mul(p, s);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_sched_if.sv
// Key-in and round-key-out handshake bundle between the key schedule and its neighbours.
interface aes_key_sched_if;
  import aes_key_sched_pkg::*;

  logic       key_valid;
  logic       key_ready;
  block_t     key_in;
  logic       rk_valid;
  logic       rk_ready;
  block_t     rk_out;
  logic [3:0] rk_idx;
  logic       rk_last;

  modport slave (
    input  key_valid, key_in, rk_ready,
    output key_ready, rk_valid, rk_out, rk_idx, rk_last
  );

  modport master (
    output key_valid, key_in, rk_ready,
    input  key_ready, rk_valid, rk_out, rk_idx, rk_last
  );
endinterface

// File: rtl/aes_key_sched_chk.sv
// Protocol and parameter checks for aes_key_sched: legal NR, stall stability, index range.
module aes_key_sched_chk
  import aes_key_sched_pkg::*;
#(
  parameter int NR = 10
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  input logic       rk_valid,
  input logic       rk_ready,
  input block_t     rk_out,
  input logic [3:0] rk_idx
);

  if (NR < 1 || NR > 10) begin : g_bad_nr
    $error("aes_key_sched: NR must be within 1..10");
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
    (rk_valid && !rk_ready && !flush) |=> (rk_valid && $stable(rk_out) && $stable(rk_idx)));

  a_idx_range: assert property (@(posedge clk) disable iff (!rst)
    rk_idx <= 4'(NR));

endmodule

// File: rtl/aes_key_sched_sub_bytes.sv
// Four parallel AES S-boxes applied to one 32-bit word (SubWord).
module sub_bytes
  import aes_key_sched_pkg::*;
(
  input  word_t bytes_in,
  output word_t bytes_out
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign bytes_out[g] = sbox_byte(bytes_in[g]);
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: accepts one key, then streams round keys 0..NR.
module aes_key_sched
  import aes_key_sched_pkg::*;
#(
  parameter int NR = 10
) (
  input logic            clk,
  input logic            rst,
  input logic            i_flush,
  aes_key_sched_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_t     r_state;
  state_t     w_state_nxt;
  block_t     r_out;
  logic [3:0] r_idx;
  logic       r_last;
  logic       w_key_ready;
  logic       w_rk_valid;
  logic       w_key_hs;
  logic       w_rk_hs;
  word_t      w_rot;
  word_t      w_sub;
  word_t      w_t;
  byte_t      w_rcon;
  block_t     w_next;

  assign w_key_hs = w_key_ready & bus.key_valid;
  assign w_rk_hs  = w_rk_valid & bus.rk_ready;
  assign w_rot    = rot_word(r_out[3]);

  sub_bytes u_sub_word (
    .bytes_in  (w_rot),
    .bytes_out (w_sub)
  );

  // Next round key from the current one; RCON lookup guarded past the table end.
  always_comb begin
    w_rcon    = (r_idx < 4'd10) ? RCON[r_idx] : 8'h00;
    w_t       = w_sub;
    w_t[0]    = w_sub[0] ^ w_rcon;
    w_next[0] = r_out[0] ^ w_t;
    w_next[1] = r_out[1] ^ w_next[0];
    w_next[2] = r_out[2] ^ w_next[1];
    w_next[3] = r_out[3] ^ w_next[2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush overrides everything; EMIT leaves only on the handshake of the last round key.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_valid) w_state_nxt = ST_EMIT;
          else               w_state_nxt = ST_IDLE;
        end
        ST_EMIT: begin
          if (w_rk_hs && (r_idx == NR_IDX)) w_state_nxt = ST_IDLE;
          else                              w_state_nxt = ST_EMIT;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_key_ready = 1'b0;
    w_rk_valid  = 1'b0;
    case (r_state)
      ST_IDLE: w_key_ready = 1'b1;
      ST_EMIT: w_rk_valid  = 1'b1;
      default: begin
        w_key_ready = 1'b0;
        w_rk_valid  = 1'b0;
      end
    endcase
  end

  // Round-key register and counter; rk_out is left untouched by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_idx  <= 4'd0;
      r_last <= 1'b0;
    end else if (i_flush) begin
      r_idx  <= 4'd0;
      r_last <= 1'b0;
    end else if (w_key_hs) begin
      r_out  <= bus.key_in;
      r_idx  <= 4'd0;
      r_last <= 1'b0;
    end else if (w_rk_hs && (r_idx < NR_IDX)) begin
      r_out  <= w_next;
      r_idx  <= r_idx + 4'd1;
      r_last <= ((r_idx + 4'd1) == NR_IDX);
    end
  end

  assign bus.key_ready = w_key_ready;
  assign bus.rk_valid  = w_rk_valid;
  assign bus.rk_out    = r_out;
  assign bus.rk_idx    = r_idx;
  assign bus.rk_last   = r_last;

  aes_key_sched_chk #(.NR(NR)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .flush    (i_flush),
    .rk_valid (w_rk_valid),
    .rk_ready (bus.rk_ready),
    .rk_out   (r_out),
    .rk_idx   (r_idx)
  );

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
Iterative AES-128 key expansion stage that sits directly upstream of the per-round datapath (SubBytes/ShiftRows/AddRoundKey). It accepts one 128-bit cipher key over a valid/ready handshake, then streams round keys 0..NR one per output handshake. Each round key is held stable until the round stage consumes it. NR is parameterisable for reduced-round experiments.

Parameters:
NR, 10, number of rounds; round keys 0..NR are emitted; legal range 1..10, checked by an elaboration-time assertion.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
flush  input  1  synchronous abort; returns to IDLE
key_valid  input  1  key_in is valid
key_ready  output  1  block can accept a key
key_in  input  [3:0][3:0][7:0]  cipher key; key_in[w][b] = FIPS-197 byte 4w+b (w = word, b = byte in word)
rk_valid  output  1  rk_out is valid
rk_ready  input  1  downstream consumes rk_out
rk_out  output  [3:0][3:0][7:0]  current round key, same byte layout as key_in
rk_idx  output  4  round index of rk_out, 0..NR
rk_last  output  1  high when rk_idx == NR

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: state IDLE, key_ready=1, rk_valid=0, rk_out=0, rk_idx=0, rk_last=0.
- States:
  - IDLE: key_ready=1, rk_valid=0.
  - EMIT: key_ready=0, rk_valid=1.
- Accepting a key: in IDLE, key_valid&&key_ready loads rk_out<=key_in and rk_idx<=0, then moves to EMIT. rk_valid rises the next cycle, so latency is 1 cycle.
- Round-key handshake in EMIT: a handshake is rk_valid&&rk_ready.
  - If rk_idx<NR: rk_out<=next(rk_out, RCON[rk_idx]) and rk_idx<=rk_idx+1.
  - If rk_idx==NR: go to IDLE; key_ready is 1 on the following cycle.
- Stall: with rk_ready low, rk_out, rk_idx and rk_last hold. rk_valid never drops without a handshake, except on flush or reset.
- next(k):
  - t = SubWord(RotWord(k[3])) ^ {rcon,0,0,0}.
  - RotWord maps bytes (b0,b1,b2,b3) to (b1,b2,b3,b0).
  - rcon XORs into byte 0 only.
  - w0'=k[0]^t, w1'=k[1]^w0', w2'=k[2]^w1', w3'=k[3]^w2'.
  - The combinational chain runs within one cycle.
- RCON[0..9] = 01,02,04,08,10,20,40,80,1b,36.
- rk_last is registered alongside rk_idx. It is high exactly on the final beat and is also high on beat 0 only if NR==0, which is illegal.
- Throughput: NR+1 output beats per key, plus one IDLE cycle before the next key is accepted. There is no overlap between keys.
- flush:
  - Has highest priority after reset and is valid in any state.
  - Next cycle: IDLE, rk_valid=0, rk_idx=0, and key_ready=1. rk_out holds its last value (don't-care).
  - flush together with key_valid in IDLE: the key is NOT accepted.
- Reset mid-EMIT: immediate return to reset values. No partial beat is emitted.
- key_valid while in EMIT is ignored because key_ready=0. The upstream must hold the key until key_ready.
- X-propagation: key_in is sampled only on a handshake. Assertions check that rk_out is stable while rk_valid&&!rk_ready, and that rk_idx<=NR.

Decomposition:
- aes_pkg holds:
  - typedefs byte_t=logic[7:0], word_t=byte_t[3:0], block_t=word_t[3:0];
  - localparam RCON table (10 x byte_t);
  - function rot_word.
- Sub-module: the existing sub_bytes (4-byte bytes_in/bytes_out) is instantiated once for SubWord. No new S-box is written.
- next() combinational logic lives in aes_key_sched.
- Control is a 2-state FSM plus a 4-bit round counter.

Test Plan:
- FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready tied high -> beats idx0 = key; idx1 = a0fafe17 88542cb1 23a33939 2a6c7605; idx10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 with rk_last=1; key_ready=1 one cycle after idx10.
- Same key with rk_ready randomly deasserted for 0-5 cycles per beat -> identical 11-key sequence; rk_out/rk_idx stable during stalls; key_ready=0 throughout.
- NR=4 build, key all-zero -> 5 beats; idx1 = 62636363 62636363 62636363 62636363; idx4 has rk_last=1, then IDLE.
- flush asserted while rk_idx=3 -> next cycle rk_valid=0, key_ready=1; new key 000102..0f accepted; its idx1 = d6aa74fd d2af72fa daa678f1 d6ab76fe.
- rst asserted low asynchronously mid-EMIT (idx=6) -> rk_valid=0, rk_idx=0, key_ready=1 before the next clk edge; key_valid held high during reset is not accepted until rst is released.
- Back-to-back keys with key_valid held high -> second key accepted exactly one cycle after the first key's idx10 handshake; no beat is dropped or duplicated.
